// File: rtl/lane_deskew.sv
// rtl/lane_deskew.sv - four-lane COM-locked receive deskew with per-lane FIFOs
// Releases one byte per lane only when every lane has data; reports skew and misalignment.
module lane_deskew #(
    parameter int         DEPTH = 8,
    parameter logic [7:0] COM   = 8'hBC,
    parameter int         SKW_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [3:0]       lane_valid,
    input  logic [7:0]       lane0_data,
    input  logic [7:0]       lane1_data,
    input  logic [7:0]       lane2_data,
    input  logic [7:0]       lane3_data,
    output logic             out_valid,
    output logic [7:0]       out0,
    output logic [7:0]       out1,
    output logic [7:0]       out2,
    output logic [7:0]       out3,
    output logic             aligned,
    output logic             skew_err,
    output logic [SKW_W-1:0] skew
);
    localparam int             PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             CW   = $clog2(DEPTH + 1);
    localparam logic [PW-1:0]  LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    typedef enum logic [1:0] {SEARCH = 2'd0, PARTIAL = 2'd1, ALIGNED = 2'd2} state_t;
    state_t state_q, state_d;

    logic [7:0]       mem_q [4][DEPTH];
    logic [7:0]       mem_d [4][DEPTH];
    logic [PW-1:0]    wp_q [4];
    logic [PW-1:0]    wp_d [4];
    logic [PW-1:0]    rp_q [4];
    logic [PW-1:0]    rp_d [4];
    logic [CW-1:0]    cnt_q [4];
    logic [CW-1:0]    cnt_d [4];
    logic [3:0]       locked_q, locked_d;
    logic [SKW_W-1:0] scnt_q, scnt_d, skew_q, skew_d, scnt_inc;
    logic             out_valid_q, out_valid_d, skew_err_q, skew_err_d;
    logic [7:0]       out_q [4];
    logic [7:0]       out_d [4];

    logic [7:0]       din [4];
    logic [7:0]       rd_byte [4];
    logic [3:0]       wr, is_com;
    logic             pop, ovf, align_loss, flush;

    assign din[0] = lane0_data;
    assign din[1] = lane1_data;
    assign din[2] = lane2_data;
    assign din[3] = lane3_data;

    // Pop and overflow decisions use only registered counts.
    always_comb begin
        pop = 1'b1;
        ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr[i]      = lane_valid[i] && (locked_q[i] || din[i] == COM);
            rd_byte[i] = mem_q[i][rp_q[i]];
            is_com[i]  = (rd_byte[i] == COM);
            if (cnt_q[i] == '0) pop = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            if (wr[i] && cnt_q[i] == FULL && !pop) ovf = 1'b1;
        end
        align_loss = (state_q == ALIGNED) && pop && (|is_com) && !(&is_com);
        flush      = ovf || align_loss;
    end

    always_comb begin
        mem_d       = mem_q;
        wp_d        = wp_q;
        rp_d        = rp_q;
        cnt_d       = cnt_q;
        locked_d    = locked_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        skew_err_d  = flush;
        scnt_d      = scnt_q;
        skew_d      = skew_q;
        scnt_inc    = (scnt_q == '1) ? scnt_q : scnt_q + SKW_W'(1);
        if (flush) begin
            locked_d = '0;
            for (int i = 0; i < 4; i++) begin
                wp_d[i]  = '0;
                rp_d[i]  = '0;
                cnt_d[i] = '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr[i]) begin
                    mem_d[i][wp_q[i]] = din[i];
                    wp_d[i]           = (wp_q[i] == LAST) ? '0 : wp_q[i] + PW'(1);
                    locked_d[i]       = 1'b1;
                end
                if (pop) rp_d[i] = (rp_q[i] == LAST) ? '0 : rp_q[i] + PW'(1);
                cnt_d[i] = cnt_q[i] + CW'(wr[i]) - CW'(pop);
            end
            if (pop) begin
                out_valid_d = 1'b1;
                out_d       = rd_byte;
            end
            // Skew counts edges from the first lane lock to the last one.
            if (state_q == SEARCH && |locked_d) begin
                scnt_d = '0;
                if (&locked_d) skew_d = '0;
            end else if (state_q == PARTIAL && !(&locked_q)) begin
                scnt_d = scnt_inc;
                if (&locked_d) skew_d = scnt_inc;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SEARCH:  if (|locked_d) state_d = PARTIAL;
            PARTIAL: if (pop) state_d = ALIGNED;
            default: state_d = state_q;
        endcase
        if (flush) state_d = SEARCH;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= SEARCH;
            locked_q    <= '0;
            scnt_q      <= '0;
            skew_q      <= '0;
            out_valid_q <= 1'b0;
            skew_err_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                wp_q[i]  <= '0;
                rp_q[i]  <= '0;
                cnt_q[i] <= '0;
                out_q[i] <= '0;
                for (int j = 0; j < DEPTH; j++) mem_q[i][j] <= '0;
            end
        end else begin
            state_q     <= state_d;
            locked_q    <= locked_d;
            scnt_q      <= scnt_d;
            skew_q      <= skew_d;
            out_valid_q <= out_valid_d;
            skew_err_q  <= skew_err_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            mem_q       <= mem_d;
        end
    end

    always_comb begin
        aligned   = (state_q == ALIGNED);
        out_valid = out_valid_q;
        skew_err  = skew_err_q;
        skew      = skew_q;
        out0      = out_q[0];
        out1      = out_q[1];
        out2      = out_q[2];
        out3      = out_q[3];
    end
endmodule

// File: doc/lane_deskew.md
Name: lane_deskew

Overview:
- Four-lane receive deskew stage. Sits between the four serial-to-parallel lane receivers and the RX byte un-striper.
- Each lane locks on the COM symbol 0xBC and buffers its bytes in a per-lane FIFO. Bytes are released to the un-striper only when every lane has data, so all four lanes leave byte-aligned.
- Detects excess skew and loss of alignment, and reports the measured inter-lane skew.

Parameters:
DEPTH, 8, per-lane FIFO depth in bytes; maximum tolerable skew is DEPTH-1 cycles
COM, 8'hBC, alignment symbol
SKW_W, 4, width of the skew report; skew counter saturates at 2^SKW_W-1

Ports:
CLK  input  1  single clock, all lanes share it
RESET  input  1  asynchronous, active-high reset
lane_valid  input  4  bit i = lane i presents a byte this cycle
lane0_data  input  8  lane 0 byte
lane1_data  input  8  lane 1 byte
lane2_data  input  8  lane 2 byte
lane3_data  input  8  lane 3 byte
out_valid  output  1  aligned 4-byte group valid this cycle
out0  output  8  lane 0 aligned byte
out1  output  8  lane 1 aligned byte
out2  output  8  lane 2 aligned byte
out3  output  8  lane 3 aligned byte
aligned  output  1  high while in ALIGNED
skew_err  output  1  one-cycle pulse on overflow or alignment loss
skew  output  SKW_W  cycles between first and last lane COM at the last lock

Behaviour:
Reset:
- RESET high clears everything asynchronously: FIFOs empty, lane locks cleared, state SEARCH.
- out_valid, out0-out3, aligned, skew_err and skew are all 0.

Lane lock:
- Lane i writes its byte when lane_valid[i] and (locked[i] or data==COM).
- A COM write sets locked[i]. Unlocked bytes that are not COM are discarded.
- Once locked, every valid byte is written, including later COMs.

States:
- SEARCH: no lane locked. The first lock moves to PARTIAL and starts the skew counter at 0.
- PARTIAL: skew counter increments every cycle. When all four lanes are locked, the counter value at that edge is latched into skew and the counter stops.
- ALIGNED: entered on the first pop.
  - The first pop after all four lanes lock is necessarily COM on all four lanes. It sets aligned=1 on the same edge.

Pop and output:
- A pop happens when all four FIFO counts are nonzero, evaluated on the registered counts. It removes one byte from each FIFO on the same edge.
- The popped bytes are registered onto out0-out3 with out_valid=1 at that edge.
- Latency: a write at edge k that completes the set pops at edge k+1. Minimum latency is 1 cycle.
- Outputs hold their last value when out_valid=0.
- Simultaneous write and pop on one FIFO leaves its count unchanged. Pointers wrap modulo DEPTH.

Overflow:
- Condition: a write to a FIFO with count==DEPTH and no pop in that cycle.
- Response on that edge: skew_err=1 for one cycle, all FIFOs flushed, all locks cleared, state SEARCH, aligned=0, out_valid=0, skew keeps its last latched value.
- The offending byte is dropped. The next COM may relock on the following cycle.

Alignment loss:
- Condition: in ALIGNED, a pop set where some lanes carry COM but not all.
- Response: out_valid=0 for that set, skew_err pulses, full flush and unlock, state SEARCH, aligned=0.
- COM on all four lanes is a normal aligned group and is output.

Simultaneous events:
- Overflow and alignment loss together produce a single skew_err pulse.
- Flush has priority over writes in the same cycle.

Test Plan:
1. Zero skew: all lanes COM at cycle 0, then 0x01, 0x02 continuously -> pop at cycle 1 gives out0-out3=BC, out_valid=1, aligned=1, skew=0. Cycle 2 gives all lanes 0x01.
2. Skew of 3: lane2 stream delayed 3 cycles relative to the others -> first out_valid group is BC on all lanes, the following groups are equal across lanes, skew=3, no skew_err.
3. Pre-COM garbage: lane0 sends 0x55, 0x66, then BC in step with the other lanes' BC -> 0x55 and 0x66 never appear, output as in test 1.
4. Overflow: lanes 0-2 send BC and then data continuously, lane3 never sends BC -> on the (DEPTH+1)th write to lane0, skew_err pulses once, out_valid stays 0, aligned=0, and a later aligned BC relocks.
5. Alignment loss: in ALIGNED, inject BC on lane1 only in one group -> that group is suppressed, skew_err pulses, aligned falls to 0, and a later common BC realigns.
6. Reset mid-stream: assert RESET asynchronously while aligned=1 and out_valid=1 -> all outputs drop to 0 immediately without waiting for a clock edge. After release, no output appears until a new COM lock.
